// File: rtl/register_universal_param.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, increment and decrement.
// Updates on the falling clock edge, gated by active-low enable, with async active-low reset.
module register_universal_param #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             Resetbar,
  input  logic             Enbar,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] in,
  input  logic             SerialIn,
  output logic [WIDTH-1:0] out,
  output logic             Carry,
  output logic             Zero
);

  if (WIDTH < 2) begin : g_width_check
    $error("register_universal_param: WIDTH must be >= 2");
  end

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    if (!Enbar) begin
      case (mode_e'(Mode))
        MODE_HOLD: begin
          out_d   = out_q;
          carry_d = carry_q;
        end
        MODE_LOAD: begin
          out_d   = in;
          carry_d = 1'b0;
        end
        MODE_SHL: begin
          out_d   = {out_q[WIDTH-2:0], SerialIn};
          carry_d = out_q[WIDTH-1];
        end
        MODE_SHR: begin
          out_d   = {SerialIn, out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        MODE_ROL: begin
          out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          carry_d = out_q[WIDTH-1];
        end
        MODE_ROR: begin
          out_d   = {out_q[0], out_q[WIDTH-1:1]};
          carry_d = out_q[0];
        end
        // The extra top bit of the widened sum/difference is the wrap flag.
        MODE_INC: {carry_d, out_d} = {1'b0, out_q} + ONE_EXT;
        MODE_DEC: {carry_d, out_d} = {1'b0, out_q} - ONE_EXT;
        // An unknown mode poisons the result instead of quietly holding.
        default: begin
          out_d   = 'x;
          carry_d = 1'bx;
        end
      endcase
    end
  end

  always_ff @(negedge Clk or negedge Resetbar) begin
    if (!Resetbar) begin
      out_q   <= RESET_VALUE;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign out   = out_q;
  assign Carry = carry_q;
  assign Zero  = (out_q == '0);

endmodule
